// File: rtl/sel_mux_pkg.sv
// rtl/sel_mux_pkg.sv - shared types and helpers for the sel_mux_reg slice
//   state_t   : output register occupancy (EMPTY / FULL)
//   sel_width : select token width for a given channel count, never below 1
package sel_mux_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin channel picker for sel_mux_reg
//   valid [N_IN] : per-channel request
//   ptr   [IDXW] : index of the most recently granted channel
//   grant [N_IN] : one-hot grant, lowest-index valid at or after ptr+1 (mod N_IN)
//   idx   [IDXW] : binary index of the granted channel (0 when no grant)
module rr_arbiter #(
    parameter int N_IN = 8,
    parameter int IDXW = 3
) (
    input  logic [N_IN-1:0] valid,
    input  logic [IDXW-1:0] ptr,
    output logic [N_IN-1:0] grant,
    output logic [IDXW-1:0] idx
);

    // Walk the ring from farthest to nearest so the last hit written is the
    // closest valid channel after the pointer.
    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        c     = 0;
        for (int k = N_IN; k >= 1; k--) begin
            c = (int'(ptr) + k) % N_IN;
            if (valid[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = IDXW'(c);
            end
        end
    end

endmodule

// File: rtl/sel_mux_reg.sv
// rtl/sel_mux_reg.sv - token-selected N-way mux into a one-entry output register
//   clk, reset            : single clock, synchronous active-high reset
//   in_data/valid/ready   : N_IN input channels of WIDTH bits
//   sel/sel_valid/ready   : select token naming the channel to forward
//   out_data/valid/ready  : registered output, 1 word/cycle throughput
//   err_oob               : one-cycle pulse after an out-of-range token is dropped
//   rr_mode               : only with SEL_MUX_RR_EN; 1 = round-robin, tokens ignored
module sel_mux_reg
    import sel_mux_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int WIDTH = 32,
    localparam int SELW = sel_width(N_IN)
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef SEL_MUX_RR_EN
    input  logic                       rr_mode,
`endif
    input  logic [N_IN-1:0][WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]            in_valid,
    output logic [N_IN-1:0]            in_ready,
    input  logic [SELW-1:0]            sel,
    input  logic                       sel_valid,
    output logic                       sel_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err_oob
);

    localparam logic [SELW:0] N_IN_W = (SELW + 1)'(N_IN);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic             err_q;

    logic             can_load;
    logic             sel_in_range;
    logic             sel_fire;
    logic             sel_oob;
    logic [N_IN-1:0]  sel_onehot;
    logic [N_IN-1:0]  pick;
    logic             fire;
    logic             oob_take;
    logic             sel_ready_c;
    logic [WIDTH-1:0] load_data;

    assign can_load     = (state == EMPTY) | out_ready;
    assign sel_in_range = {1'b0, sel} < N_IN_W;

    // Decoded token; all-zero when the token names a channel that does not exist.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_IN; i++) begin
            sel_onehot[i] = (sel == SELW'(i));
        end
    end

    assign sel_fire = ~reset & sel_valid & sel_in_range & (|(sel_onehot & in_valid)) & can_load;
    // Out-of-range tokens are dropped even while the register is stalled.
    assign sel_oob  = ~reset & sel_valid & ~sel_in_range;

`ifdef SEL_MUX_RR_EN
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] rr_idx;
    logic [N_IN-1:0] rr_grant;

    rr_arbiter #(
        .N_IN (N_IN),
        .IDXW (SELW)
    ) u_rr_arbiter (
        .valid (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    always_comb begin
        if (rr_mode) begin
            pick        = rr_grant;
            fire        = ~reset & (|rr_grant) & can_load;
            oob_take    = 1'b0;
            sel_ready_c = 1'b0;
        end else begin
            pick        = sel_valid ? sel_onehot : '0;
            fire        = sel_fire;
            oob_take    = sel_oob;
            sel_ready_c = sel_fire | sel_oob;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (rr_mode && fire) begin
            rr_ptr <= rr_idx;
        end
    end
`else
    always_comb begin
        pick        = sel_valid ? sel_onehot : '0;
        fire        = sel_fire;
        oob_take    = sel_oob;
        sel_ready_c = sel_fire | sel_oob;
    end
`endif

    // Ready is offered on the chosen channel regardless of its valid.
    assign in_ready  = (~reset & can_load) ? pick : '0;
    assign sel_ready = sel_ready_c;

    always_comb begin
        load_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            load_data = load_data | (in_data[i] & {WIDTH{pick[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= oob_take;
            if (fire) begin
                state  <= FULL;
                data_q <= load_data;
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = data_q;
    assign err_oob   = err_q;

endmodule

// File: doc/sel_mux_reg.md
SEL_MUX_REG -- requirements
Module: sel_mux_reg

Interface
REQ-001 SHALL have parameter N_IN, default 8, number of input channels (2..32).
REQ-002 SHALL have parameter WIDTH, default 32, data bits per channel.
REQ-003 SHALL derive local SELW = max(1, $clog2(N_IN)).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  in  N_IN x WIDTH  per-channel data.
REQ-007 SHALL have port in_valid  in  N_IN  per-channel valid.
REQ-008 SHALL have port in_ready  out  N_IN  per-channel ready.
REQ-009 SHALL have port sel  in  SELW  select token value.
REQ-010 SHALL have port sel_valid  in  1  select token valid.
REQ-011 SHALL have port sel_ready  out  1  select token accepted.
REQ-012 SHALL have port out_data  out  WIDTH  registered output data.
REQ-013 SHALL have port out_valid  out  1  output register full.
REQ-014 SHALL have port out_ready  in  1  downstream accepts.
REQ-015 SHALL have port err_oob  out  1  one-cycle pulse, out-of-range sel consumed.

Function
REQ-016 SHALL hold a one-entry output register with FSM states EMPTY and FULL; out_valid = (state == FULL).
REQ-017 SHALL define can_load = (state == EMPTY) | out_ready.
REQ-018 SHALL fire when sel_valid & sel < N_IN & in_valid[sel] & can_load: load in_data[sel], consume sel and channel sel, in the same cycle.
REQ-019 SHALL assert in_ready[i] only when i == sel, sel_valid and can_load; all other in_ready bits 0; in_ready never depends on in_valid.
REQ-020 SHALL assert sel_ready = fire, or (sel_valid & sel >= N_IN), the latter independent of can_load.
REQ-021 SHALL discard an out-of-range sel, leave state and data unchanged, and pulse err_oob the following cycle.
REQ-022 SHALL transition EMPTY->FULL on fire; FULL->EMPTY on out_ready without fire; FULL->FULL with new data on simultaneous out_ready and fire, giving throughput 1 word/cycle.
REQ-023 SHALL present data with latency exactly 1 cycle from fire to out_valid.
REQ-024 SHALL hold out_data stable while out_valid & !out_ready.
REQ-025 SHALL never consume sel when the selected channel is not valid; sel waits (no reordering).

Reset
REQ-026 SHALL on reset force state EMPTY, out_valid 0, out_data 0, err_oob 0, RR pointer 0; all ready outputs 0 during reset.
REQ-027 SHALL drop any held word on reset asserted mid-transfer; no token consumed that cycle.

Configuration
REQ-028 SHALL, with SEL_MUX_RR_EN defined, add input port rr_mode (1 bit); rr_mode=1 ignores sel/sel_valid (sel_ready=0) and grants the lowest-index valid channel at or after pointer+1 (mod N_IN), pointer updating to the granted index on fire.
REQ-029 SHALL, without SEL_MUX_RR_EN, omit rr_mode, the pointer and the arbiter; behaviour per REQ-016..025 only.

Structure
REQ-030 SHALL place state enum (EMPTY, FULL) and SELW helper function in package sel_mux_pkg.
REQ-031 SHALL put round-robin selection in sub-module rr_arbiter (N_IN param: valid vector, pointer in; one-hot grant, index out), instantiated only under SEL_MUX_RR_EN.

Verification
REQ-032 Basic: N_IN=8, WIDTH=32, in_data[5]=0xA5A5_0005 valid, sel=5, out_ready=1 -> in_ready=0b0010_0000, out_valid next cycle, out_data=0xA5A5_0005.
REQ-033 Backpressure: out_ready=0 after load, sel=2 valid with channel 2 valid -> no fire, out_data held, in_ready all 0 until out_ready=1; then load on that cycle.
REQ-034 Streaming: sel sequence 0,1,2,3 back-to-back, all valid, out_ready=1 -> four outputs on four consecutive cycles, in order.
REQ-035 Out-of-range: N_IN=6, sel=7 -> sel_ready=1, no data change, err_oob=1 next cycle only.
REQ-036 Reset mid-operation: FULL with out_ready=0, assert reset 1 cycle -> out_valid=0, out_data=0, held word lost.
REQ-037 RR (macro on): rr_mode=1, channels 1,3,6 valid, pointer 0 -> grants 1,3,6,1 on successive fires.
